q_meas_scheduler: RTL and testbench

- Sequences several charge-measurement channels. Each channel serializes pulses and reports a measured charge value with a ready flag.
- Per channel: asserts start, waits for ready (or a timeout), captures the measured charge and forwards it over a valid/ready stream tagged with the channel index.
- Enabled channels are visited round-robin. One pass over all enabled channels is a frame.

---
 rtl/q_meas_scheduler.sv | 173 +++++++++++++++++
 tb/tb_q_meas_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/q_meas_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : q_meas_scheduler
// Description : Round-robin sequencer for charge-measurement channels; starts
//               each enabled channel, captures its result or a timeout, and
//               streams it out tagged with the channel index.
// Revision    : 1.0 - initial release
// ============================================================================
module q_meas_scheduler #(
  parameter int N_CH           = 4,
  parameter int BUS_WIDTH      = 10,
  parameter int CH_W           = 2,
  parameter int TIMEOUT_CYCLES = 200,
  parameter int TO_W           = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [N_CH-1:0]           ch_mask,
  output logic [N_CH-1:0]           meas_start,
  input  logic [N_CH-1:0]           meas_ready,
  input  logic [N_CH*BUS_WIDTH-1:0] meas_q,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BUS_WIDTH-1:0]      out_data,
  output logic [CH_W-1:0]           out_ch,
  output logic                      out_timeout,
  output logic                      busy,
  output logic                      frame_done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_SETTLE  = 3'd2,
    S_EMIT    = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] c_to_one  = TO_W'(1);
  localparam logic [N_CH-1:0] c_one_hot = N_CH'(1);

  state_t            r_state;
  logic [CH_W-1:0]   r_cur;
  logic [N_CH-1:0]   r_frame_mask;
  logic [TO_W-1:0]   r_to_cnt;

  logic [CH_W-1:0]      w_low_idx;
  logic [CH_W-1:0]      w_next_idx;
  logic                 w_has_next;
  logic                 w_ready_cur;
  logic [BUS_WIDTH-1:0] w_q_cur;
  logic                 w_start_ok;

  assign w_start_ok = enable && (ch_mask != '0);

  // Priority scans run from the top down so the lowest qualifying index wins.
  always_comb begin
    w_low_idx   = '0;
    w_next_idx  = '0;
    w_has_next  = 1'b0;
    w_ready_cur = 1'b0;
    w_q_cur     = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        w_low_idx = CH_W'(i);
      end
      if (r_frame_mask[i] && (CH_W'(i) > r_cur)) begin
        w_next_idx = CH_W'(i);
        w_has_next = 1'b1;
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      if (r_cur == CH_W'(i)) begin
        w_ready_cur = meas_ready[i];
        w_q_cur     = meas_q[i*BUS_WIDTH +: BUS_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cur        <= '0;
      r_frame_mask <= '0;
      r_to_cnt     <= '0;
      meas_start   <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_ch       <= '0;
      out_timeout  <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_frame_mask <= ch_mask;
            r_cur        <= w_low_idx;
            meas_start   <= c_one_hot << w_low_idx;
            r_to_cnt     <= '0;
            busy         <= 1'b1;
            r_state      <= S_ARM;
          end
        end

        S_ARM: begin
          if (w_ready_cur) begin
            r_state <= S_SETTLE;
          end else if (r_to_cnt == c_to_last) begin
            out_data    <= '0;
            out_timeout <= 1'b1;
            out_ch      <= r_cur;
            out_valid   <= 1'b1;
            r_state     <= S_EMIT;
          end else if (r_to_cnt != '1) begin
            r_to_cnt <= r_to_cnt + c_to_one;
          end
        end

        // The channel registers its result one cycle after raising ready.
        S_SETTLE: begin
          out_data    <= w_q_cur;
          out_ch      <= r_cur;
          out_timeout <= 1'b0;
          out_valid   <= 1'b1;
          r_state     <= S_EMIT;
        end

        S_EMIT: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            meas_start <= '0;
            r_state    <= S_RELEASE;
          end
        end

        // Dropping enable ends the frame here, after the current result left.
        S_RELEASE: begin
          if (enable && w_has_next) begin
            r_cur      <= w_next_idx;
            meas_start <= c_one_hot << w_next_idx;
            r_to_cnt   <= '0;
            r_state    <= S_ARM;
          end else begin
            frame_done <= 1'b1;
            if (w_start_ok) begin
              r_frame_mask <= ch_mask;
              r_cur        <= w_low_idx;
              meas_start   <= c_one_hot << w_low_idx;
              r_to_cnt     <= '0;
              r_state      <= S_ARM;
            end else begin
              busy    <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end

        default: begin
          meas_start <= '0;
          out_valid  <= 1'b0;
          busy       <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_q_meas_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_q_meas_scheduler
// Description : Self-checking bench for q_meas_scheduler with channel models
//               and a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_q_meas_scheduler;

  localparam int N_CH           = 4;
  localparam int BUS_WIDTH      = 10;
  localparam int CH_W           = 2;
  localparam int TIMEOUT_CYCLES = 200;
  localparam int TO_W           = 8;
  localparam int DELAY          = 5;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      enable;
  logic [N_CH-1:0]           ch_mask;
  logic [N_CH-1:0]           meas_start;
  logic [N_CH-1:0]           meas_ready;
  logic [N_CH*BUS_WIDTH-1:0] meas_q;
  logic                      out_valid;
  logic                      out_ready;
  logic [BUS_WIDTH-1:0]      out_data;
  logic [CH_W-1:0]           out_ch;
  logic                      out_timeout;
  logic                      busy;
  logic                      frame_done;

  q_meas_scheduler #(
    .N_CH(N_CH), .BUS_WIDTH(BUS_WIDTH), .CH_W(CH_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_W(TO_W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .ch_mask(ch_mask),
    .meas_start(meas_start), .meas_ready(meas_ready), .meas_q(meas_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_timeout(out_timeout), .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [BUS_WIDTH-1:0] chan_val(input int i);
    return BUS_WIDTH'((i + 1) * 30);
  endfunction

  // Channel model: ready DELAY cycles after start (or at once when fast),
  // value registered one cycle after ready, all cleared while start is low.
  logic [N_CH-1:0]      hang;
  logic [N_CH-1:0]      fast;
  logic [N_CH-1:0]      r_ready;
  int                   cnt   [N_CH];
  logic [BUS_WIDTH-1:0] q_reg [N_CH];

  assign meas_ready = r_ready | (meas_start & fast & ~hang);

  always @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (!meas_start[i]) begin
        cnt[i]     <= 0;
        r_ready[i] <= 1'b0;
        q_reg[i]   <= '0;
      end else begin
        cnt[i]     <= cnt[i] + 1;
        r_ready[i] <= !hang[i] && (cnt[i] + 1 >= DELAY);
        q_reg[i]   <= meas_ready[i] ? chan_val(i) : '0;
      end
    end
  end

  always_comb begin
    meas_q = '0;
    for (int i = 0; i < N_CH; i++) meas_q[i*BUS_WIDTH +: BUS_WIDTH] = q_reg[i];
  end

  // Scoreboard and monitor
  typedef struct {
    logic [CH_W-1:0]      ch;
    logic [BUS_WIDTH-1:0] data;
    logic                 to;
    int                   lat;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   rises [N_CH];
  int   start_cyc [N_CH];
  int   valid_cyc = 0;
  int   fd_count = 0;
  int   multihot = 0;
  logic [N_CH-1:0] prev_start = '0;
  logic            prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < N_CH; i++) begin
      if (meas_start[i] && !prev_start[i]) begin
        rises[i]++;
        start_cyc[i] = cyc;
      end
    end
    if (!$onehot0(meas_start)) multihot++;
    if (out_valid && !prev_valid) valid_cyc = cyc;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 64'(out_ch), 64'(N_CH));
      end else begin
        e = sb.pop_front();
        chk("out_ch", 64'(out_ch), 64'(e.ch));
        chk("out_data", 64'(out_data), 64'(e.data));
        chk("out_timeout", 64'(out_timeout), 64'(e.to));
        chk("latency", 64'(valid_cyc - start_cyc[e.ch]), 64'(e.lat));
      end
    end
    if (frame_done) begin
      fd_count++;
      chk("frame_done_pending_results", 64'(sb.size()), 64'd0);
    end
    prev_start = meas_start;
    prev_valid = out_valid;
  end

  task automatic push_frame(input logic [N_CH-1:0] m, input logic [N_CH-1:0] h,
                            input logic [N_CH-1:0] f);
    for (int i = 0; i < N_CH; i++) begin
      if (m[i]) begin
        sb.push_back('{ch: CH_W'(i), data: (h[i] ? '0 : chan_val(i)), to: h[i],
                       lat: (h[i] ? TIMEOUT_CYCLES : (f[i] ? 2 : DELAY + 2))});
      end
    end
  endtask

  task automatic wait_fd(input int fd0, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (fd_count > fd0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [N_CH-1:0] started_since(input int snap [N_CH]);
    logic [N_CH-1:0] m;
    m = '0;
    for (int i = 0; i < N_CH; i++) m[i] = (rises[i] != snap[i]);
    return m;
  endfunction

  typedef struct {
    logic [N_CH-1:0] mask;
    logic [N_CH-1:0] hang;
    logic [N_CH-1:0] fast;
    logic [N_CH-1:0] exp_started;
    int              exp_frames;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int  snap [N_CH];
    int  fd0;
    bit  ok;
    bit  stable;

    vecs[0] = '{mask: 4'b1111, hang: 4'b0000, fast: 4'b0000, exp_started: 4'b1111, exp_frames: 1};
    vecs[1] = '{mask: 4'b1010, hang: 4'b0000, fast: 4'b0000, exp_started: 4'b1010, exp_frames: 1};
    vecs[2] = '{mask: 4'b1111, hang: 4'b0100, fast: 4'b0000, exp_started: 4'b1111, exp_frames: 1};
    vecs[3] = '{mask: 4'b0110, hang: 4'b0000, fast: 4'b0110, exp_started: 4'b0110, exp_frames: 1};
    vecs[4] = '{mask: 4'b1001, hang: 4'b0000, fast: 4'b1000, exp_started: 4'b1001, exp_frames: 1};
    vecs[5] = '{mask: 4'b0000, hang: 4'b0000, fast: 4'b0000, exp_started: 4'b0000, exp_frames: 0};

    for (int i = 0; i < N_CH; i++) begin
      rises[i] = 0;
      start_cyc[i] = 0;
    end
    rst = 1'b1; enable = 1'b0; ch_mask = '0; out_ready = 1'b1;
    hang = '0; fast = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_meas_start", 64'(meas_start), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_ch", 64'(out_ch), 64'd0);
    chk("rst_out_timeout", 64'(out_timeout), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Table-driven single frames
    for (int v = 0; v < 6; v++) begin
      hang = vecs[v].hang;
      fast = vecs[v].fast;
      snap = rises;
      fd0  = fd_count;
      push_frame(vecs[v].mask, vecs[v].hang, vecs[v].fast);
      @(posedge clk); #1 enable = 1'b1; ch_mask = vecs[v].mask;
      @(posedge clk); #1 ch_mask = '0;
      if (vecs[v].mask != '0) begin
        wait_fd(fd0, 2000, ok);
        chk("frame_done_wait", 64'(ok), 64'd1);
      end else begin
        repeat (20) @(negedge clk);
      end
      repeat (3) @(negedge clk);
      chk("frames", 64'(fd_count - fd0), 64'(vecs[v].exp_frames));
      chk("started_channels", 64'(started_since(snap)), 64'(vecs[v].exp_started));
      chk("results_missing", 64'(sb.size()), 64'd0);
      chk("busy_after_frame", 64'(busy), 64'd0);
      enable = 1'b0;
      sb.delete();
    end
    hang = '0; fast = '0;

    // Backpressure: hold out_ready low for more than 10 EMIT cycles
    fd0 = fd_count;
    push_frame(4'b0001, 4'b0000, 4'b0000);
    @(posedge clk); #1 enable = 1'b1; ch_mask = 4'b0001; out_ready = 1'b0;
    @(posedge clk); #1 ch_mask = '0;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      ok = out_valid;
    end
    chk("bp_valid_wait", 64'(ok), 64'd1);
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!(out_valid === 1'b1 && out_data === chan_val(0) && out_ch === 2'd0 &&
            meas_start === 4'b0001)) stable = 1'b0;
    end
    chk("bp_hold_stable", 64'(stable), 64'd1);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_valid_after_transfer", 64'(out_valid), 64'd0);
    wait_fd(fd0, 50, ok);
    chk("bp_frame_done", 64'(ok), 64'd1);
    enable = 1'b0;
    sb.delete();

    // enable dropped while ch1 is in ARM
    repeat (3) @(negedge clk);
    snap = rises;
    fd0  = fd_count;
    push_frame(4'b0011, 4'b0000, 4'b0000);
    @(posedge clk); #1 enable = 1'b1; ch_mask = 4'b1111;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      ok = meas_start[1];
    end
    chk("drop_ch1_started", 64'(ok), 64'd1);
    @(posedge clk); #1 enable = 1'b0;
    wait_fd(fd0, 100, ok);
    chk("drop_frame_done", 64'(ok), 64'd1);
    repeat (3) @(negedge clk);
    chk("drop_busy", 64'(busy), 64'd0);
    chk("drop_started", 64'(started_since(snap)), 64'b0011);
    chk("drop_results_missing", 64'(sb.size()), 64'd0);
    ch_mask = '0;
    sb.delete();

    // Reset asserted during EMIT, then restart at the lowest enabled channel
    push_frame(4'b0001, 4'b0000, 4'b0000);
    @(posedge clk); #1 enable = 1'b1; ch_mask = 4'b0001; out_ready = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      ok = out_valid;
    end
    chk("rst_emit_valid_wait", 64'(ok), 64'd1);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("rst_async_out_valid", 64'(out_valid), 64'd0);
    chk("rst_async_meas_start", 64'(meas_start), 64'd0);
    chk("rst_async_busy", 64'(busy), 64'd0);
    sb.delete();
    ch_mask = 4'b0110; out_ready = 1'b1;
    @(negedge clk);
    snap = rises;
    fd0  = fd_count;
    push_frame(4'b0110, 4'b0000, 4'b0000);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 ch_mask = '0;
    wait_fd(fd0, 200, ok);
    chk("restart_frame_done", 64'(ok), 64'd1);
    repeat (2) @(negedge clk);
    chk("restart_started", 64'(started_since(snap)), 64'b0110);
    chk("restart_results_missing", 64'(sb.size()), 64'd0);
    enable = 1'b0;

    chk("meas_start_multi_hot", 64'(multihot), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
